// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions: opcode encodings, link register index and flag bit positions.
package simplerisc_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_MUL  = 5'b00010;
   localparam logic [4:0] OP_DIV  = 5'b00011;
   localparam logic [4:0] OP_MOD  = 5'b00100;
   localparam logic [4:0] OP_CMP  = 5'b00101;
   localparam logic [4:0] OP_AND  = 5'b00110;
   localparam logic [4:0] OP_OR   = 5'b00111;
   localparam logic [4:0] OP_NOT  = 5'b01000;
   localparam logic [4:0] OP_MOV  = 5'b01001;
   localparam logic [4:0] OP_LSL  = 5'b01010;
   localparam logic [4:0] OP_LSR  = 5'b01011;
   localparam logic [4:0] OP_ASR  = 5'b01100;
   localparam logic [4:0] OP_NOP  = 5'b01101;
   localparam logic [4:0] OP_LD   = 5'b01110;
   localparam logic [4:0] OP_ST   = 5'b01111;
   localparam logic [4:0] OP_BEQ  = 5'b10000;
   localparam logic [4:0] OP_BGT  = 5'b10001;
   localparam logic [4:0] OP_B    = 5'b10010;
   localparam logic [4:0] OP_CALL = 5'b10011;
   localparam logic [4:0] OP_RET  = 5'b10100;

   localparam int RA_IDX  = 15;
   localparam int FLAG_GT = 1;
   localparam int FLAG_E  = 0;

endpackage

// File: rtl/event_counter.sv
// Free-running event counter; increments once per cycle with inc high and wraps at 2^CNT_W.
module event_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ex_ma_stage.sv
// SimpleRisc EX/MA pipeline register: owns the flags register, resolves branches, issues a
// one-cycle redirect that kills the wrong-path instruction behind it, and counts retirements.
module ex_ma_stage
   import simplerisc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int RD_W   = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_opcode,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [1:0]        in_alu_flags,
   input  logic [DATA_W-1:0] in_op1,
   input  logic [DATA_W-1:0] in_op2,
   input  logic [PC_W-1:0]   in_target,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_is_wb,

   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_opcode,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_store_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_is_wb,

   output logic [1:0]        flags,
   output logic              branch_taken,
   output logic [PC_W-1:0]   branch_pc,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   logic            fire;
   logic            accept;
   logic            br_cond;
   logic            br_take;
   logic [PC_W-1:0] br_target;

   assign in_ready = ~out_valid | out_ready;
   assign fire     = in_valid & in_ready;
   // The instruction arriving while a redirect is out is on the wrong path and is dropped.
   assign accept   = fire & ~branch_taken;
   assign br_take  = accept & br_cond;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      br_cond   = 1'b0;
      br_target = in_target;
      case (in_opcode)
         OP_BEQ:  br_cond = flags[FLAG_E];
         OP_BGT:  br_cond = flags[FLAG_GT];
         OP_B,
         OP_CALL: br_cond = 1'b1;
         OP_RET: begin
            br_cond   = 1'b1;
            br_target = in_op1[PC_W-1:0];
         end
         default: br_cond = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_opcode     <= '0;
         out_pc         <= '0;
         out_result     <= '0;
         out_store_data <= '0;
         out_rd         <= '0;
         out_is_wb      <= 1'b0;
         flags          <= 2'b00;
         branch_taken   <= 1'b0;
         branch_pc      <= '0;
      end else begin
         branch_taken <= br_take;
         if (br_take) begin
            branch_pc <= br_target;
         end

         if (accept) begin
            out_valid      <= 1'b1;
            out_opcode     <= in_opcode;
            out_pc         <= in_pc;
            out_store_data <= in_op2;
            if (in_opcode == OP_CALL) begin
               out_result <= DATA_W'(in_pc + PC_W'(4));
               out_rd     <= RD_W'(RA_IDX);
               out_is_wb  <= 1'b1;
            end else begin
               out_result <= in_alu_result;
               out_rd     <= in_rd;
               out_is_wb  <= in_is_wb & (in_opcode != OP_NOP);
            end
            if (in_opcode == OP_CMP) begin
               flags <= in_alu_flags;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   event_counter #(.CNT_W(CNT_W)) u_retired_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (accept),
      .count (retired_cnt)
   );

   event_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (br_take),
      .count (taken_cnt)
   );

endmodule
